mem_port_arbiter: RTL

- Shares one wait-stated memory port between the CPU's instruction-fetch requester and data (load/store) requester.
- Sits between the pipeline's fetch/memory stages and the external bus, and sequences each access through a small FSM.
- Returns a one-cycle valid pulse to the requester it served.
- Gives the pipeline a single `busy` indication for stall generation.

---
 rtl/mem_port_arbiter.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one wait-stated memory port between the instruction-fetch
//   requester and the data (load/store) requester. Each access is
//   sequenced IDLE -> BUS -> RESP. The served requester gets a one-cycle
//   valid pulse in RESP. When both requesters are pending, the grant
//   goes to the one that was not granted last.
//
// Optional feature (compile-time macro MEM_ARBITER_IFETCH_BUFFER_EN):
//   Adds a one-entry fetch buffer {valid, address, word}. A granted fetch
//   that hits the buffer skips BUS and goes straight to RESP. A completed
//   store to the buffered address invalidates the entry.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   instr_req/instr_address     fetch request (held until instr_valid)
//   instr_readdata/instr_valid  fetch response
//   data_read/data_write        load / store request (never both high)
//   data_address/data_writedata/data_byteenable  load/store payload
//   data_readdata/data_valid    load/store response
//   mem_*                       registered external bus master side
//   mem_waitrequest/mem_readdata  bus slave side
//   busy                        high while an access is on the bus
module mem_port_arbiter #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              instr_req,
   input  logic [ADDR_W-1:0] instr_address,
   output logic [31:0]       instr_readdata,
   output logic              instr_valid,
   input  logic              data_read,
   input  logic              data_write,
   input  logic [ADDR_W-1:0] data_address,
   input  logic [31:0]       data_writedata,
   input  logic [3:0]        data_byteenable,
   output logic [31:0]       data_readdata,
   output logic              data_valid,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_read,
   output logic              mem_write,
   output logic [31:0]       mem_writedata,
   output logic [3:0]        mem_byteenable,
   input  logic              mem_waitrequest,
   input  logic [31:0]       mem_readdata,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

   localparam logic GRANT_INSTR = 1'b0;
   localparam logic GRANT_DATA  = 1'b1;

   state_t            state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              winner_q, winner_d;
   logic [ADDR_W-1:0] mem_address_q, mem_address_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic [31:0]       mem_writedata_q, mem_writedata_d;
   logic [3:0]        mem_byteenable_q, mem_byteenable_d;
   logic [31:0]       instr_readdata_q, instr_readdata_d;
   logic [31:0]       data_readdata_q, data_readdata_d;
   logic              instr_valid_q, instr_valid_d;
   logic              data_valid_q, data_valid_d;

   logic              data_req;
   logic              grant_data;
   logic              ibuf_hit;
   logic [31:0]       ibuf_word;

`ifdef MEM_ARBITER_IFETCH_BUFFER_EN
   logic              ibuf_valid_q, ibuf_valid_d;
   logic [ADDR_W-1:0] ibuf_addr_q, ibuf_addr_d;
   logic [31:0]       ibuf_word_q, ibuf_word_d;

   assign ibuf_hit  = ibuf_valid_q && (ibuf_addr_q == instr_address);
   assign ibuf_word = ibuf_word_q;

   // Every bus-completed fetch refills the entry; a completed store to
   // the buffered address makes it stale.
   always_comb begin
      ibuf_valid_d = ibuf_valid_q;
      ibuf_addr_d  = ibuf_addr_q;
      ibuf_word_d  = ibuf_word_q;
      if (state_q == BUS && !mem_waitrequest) begin
         if (mem_read_q && winner_q == GRANT_INSTR) begin
            ibuf_valid_d = 1'b1;
            ibuf_addr_d  = mem_address_q;
            ibuf_word_d  = mem_readdata;
         end else if (mem_write_q && mem_address_q == ibuf_addr_q) begin
            ibuf_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ibuf_valid_q <= 1'b0;
         ibuf_addr_q  <= '0;
         ibuf_word_q  <= '0;
      end else begin
         ibuf_valid_q <= ibuf_valid_d;
         ibuf_addr_q  <= ibuf_addr_d;
         ibuf_word_q  <= ibuf_word_d;
      end
   end
`else
   assign ibuf_hit  = 1'b0;
   assign ibuf_word = '0;
`endif

   assign data_req = data_read | data_write;

   // Under contention the requester not served last wins.
   always_comb begin
      grant_data = data_req;
      if (data_req && instr_req) begin
         grant_data = (last_grant_q == GRANT_INSTR);
      end
   end

   always_comb begin
      state_d          = state_q;
      last_grant_d     = last_grant_q;
      winner_d         = winner_q;
      mem_address_d    = mem_address_q;
      mem_read_d       = mem_read_q;
      mem_write_d      = mem_write_q;
      mem_writedata_d  = mem_writedata_q;
      mem_byteenable_d = mem_byteenable_q;
      instr_readdata_d = instr_readdata_q;
      data_readdata_d  = data_readdata_q;
      instr_valid_d    = 1'b0;
      data_valid_d     = 1'b0;

      case (state_q)
         // RESP arbitrates exactly like IDLE; requests seen here are new.
         IDLE, RESP: begin
            state_d = IDLE;
            if (data_req || instr_req) begin
               last_grant_d = grant_data;
               winner_d     = grant_data;
               if (grant_data) begin
                  state_d          = BUS;
                  mem_address_d    = data_address;
                  mem_read_d       = data_read;
                  mem_write_d      = data_write;
                  mem_writedata_d  = data_writedata;
                  mem_byteenable_d = data_write ? data_byteenable : 4'b1111;
               end else if (ibuf_hit) begin
                  state_d          = RESP;
                  instr_valid_d    = 1'b1;
                  instr_readdata_d = ibuf_word;
               end else begin
                  state_d          = BUS;
                  mem_address_d    = instr_address;
                  mem_read_d       = 1'b1;
                  mem_write_d      = 1'b0;
                  mem_byteenable_d = 4'b1111;
               end
            end
         end
         BUS: begin
            if (!mem_waitrequest) begin
               state_d     = RESP;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               if (winner_q == GRANT_DATA) begin
                  data_valid_d = 1'b1;
                  // Stores leave the load word untouched.
                  if (mem_read_q) begin
                     data_readdata_d = mem_readdata;
                  end
               end else begin
                  instr_valid_d    = 1'b1;
                  instr_readdata_d = mem_readdata;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= IDLE;
         last_grant_q     <= GRANT_INSTR;
         winner_q         <= GRANT_INSTR;
         mem_address_q    <= '0;
         mem_read_q       <= 1'b0;
         mem_write_q      <= 1'b0;
         mem_writedata_q  <= '0;
         mem_byteenable_q <= '0;
         instr_readdata_q <= '0;
         data_readdata_q  <= '0;
         instr_valid_q    <= 1'b0;
         data_valid_q     <= 1'b0;
      end else begin
         state_q          <= state_d;
         last_grant_q     <= last_grant_d;
         winner_q         <= winner_d;
         mem_address_q    <= mem_address_d;
         mem_read_q       <= mem_read_d;
         mem_write_q      <= mem_write_d;
         mem_writedata_q  <= mem_writedata_d;
         mem_byteenable_q <= mem_byteenable_d;
         instr_readdata_q <= instr_readdata_d;
         data_readdata_q  <= data_readdata_d;
         instr_valid_q    <= instr_valid_d;
         data_valid_q     <= data_valid_d;
      end
   end

   assign mem_address    = mem_address_q;
   assign mem_read       = mem_read_q;
   assign mem_write      = mem_write_q;
   assign mem_writedata  = mem_writedata_q;
   assign mem_byteenable = mem_byteenable_q;
   assign instr_readdata = instr_readdata_q;
   assign data_readdata  = data_readdata_q;
   assign instr_valid    = instr_valid_q;
   assign data_valid     = data_valid_q;
   assign busy           = (state_q == BUS);

endmodule
